uart_tx_arbiter: RTL and testbench

- Shares one UART transmitter among N_REQ byte producers: status reporter, echo path, debug dump.
- Round-robin arbitration, with optional per-requester grant lock for multi-byte packets.
- Sequences the UART ready/done transmit handshake.
- Sits between requester logic and the `uart` instance, in the `clk_uart` domain.

---
 rtl/uart_tx_arbiter.sv | 136 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter, with a per-requester grant lock; grant lands 1 cycle after req_valid.
// Requesters hold their byte until req_ack; done->ack->idle->ready is 3 cycles. `UART_ARB_TIMEOUT_EN adds a SEND watchdog.
module uart_tx_arbiter #(
  parameter int N_REQ          = 3,
  parameter int TIMEOUT_CYCLES = 65536,
  localparam int GW            = (N_REQ > 2) ? $clog2(N_REQ) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [8*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]   req_lock,
  output logic [N_REQ-1:0]   req_ack,
  output logic [7:0]         uart_data,
  output logic               uart_ready,
  input  logic               uart_done,
  output logic [GW-1:0]      grant_id,
  output logic               busy,
  output logic               err
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SEND = 2'd1;
  localparam logic [1:0] GAP  = 2'd2;

  logic [1:0]       state;
  logic [GW-1:0]    ptr;
  logic             lock_hold;
  logic [7:0]       req_bytes [N_REQ];
  logic             grant_vld;
  logic [GW-1:0]    grant_sel;
  logic [GW-1:0]    cand;
  logic [GW-1:0]    ptr_nxt;
  logic [N_REQ-1:0] ack_vec;
  logic             to_abort;

  for (genvar g = 0; g < N_REQ; g++) begin : g_bytes
    assign req_bytes[g] = req_data[8*g +: 8];
  end

  // A held lock either re-grants its owner or blocks everyone while the owner is idle.
  always_comb begin
    grant_vld = 1'b0;
    grant_sel = '0;
    cand      = '0;
    if (lock_hold) begin
      grant_vld = req_valid[grant_id];
      grant_sel = grant_id;
    end else begin
      for (int k = 0; k < N_REQ; k++) begin
        cand = GW'((int'(ptr) + k) % N_REQ);
        if (!grant_vld && req_valid[cand]) begin
          grant_vld = 1'b1;
          grant_sel = cand;
        end
      end
    end
  end

  assign ptr_nxt = (grant_id == GW'(N_REQ - 1)) ? '0 : grant_id + 1'b1;
  assign ack_vec = N_REQ'(1) << grant_id;

`ifdef UART_ARB_TIMEOUT_EN
  localparam logic [16:0] TO_LAST = 17'(TIMEOUT_CYCLES - 1);

  logic [16:0] to_cnt;

  assign to_abort = (state == SEND) && !uart_done && (to_cnt == TO_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt <= '0;
      err    <= 1'b0;
    end else begin
      err <= to_abort;
      if (state != SEND || uart_done || to_abort) begin
        to_cnt <= '0;
      end else begin
        to_cnt <= to_cnt + 17'd1;
      end
    end
  end
`else
  logic unused_timeout;

  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign to_abort       = 1'b0;
  assign err            = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      uart_ready <= 1'b0;
      uart_data  <= '0;
      req_ack    <= '0;
      grant_id   <= '0;
      busy       <= 1'b0;
      ptr        <= '0;
      lock_hold  <= 1'b0;
    end else begin
      req_ack <= '0;
      case (state)
        IDLE: begin
          if (grant_vld) begin
            state      <= SEND;
            uart_data  <= req_bytes[grant_sel];
            grant_id   <= grant_sel;
            uart_ready <= 1'b1;
            busy       <= 1'b1;
          end
        end
        SEND: begin
          if (uart_done || to_abort) begin
            state      <= GAP;
            uart_ready <= 1'b0;
            req_ack    <= ack_vec;
            ptr        <= ptr_nxt;
            // An aborted byte never keeps the lock.
            lock_hold  <= uart_done ? req_lock[grant_id] : 1'b0;
          end
        end
        GAP: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state      <= IDLE;
          uart_ready <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: expected (grant, byte) pairs are queued as requests are driven and
// popped when uart_ready rises; define UART_ARB_TIMEOUT_EN to also run the watchdog scenario.
module tb_uart_tx_arbiter;

  localparam int N = 3;
`ifdef UART_ARB_TIMEOUT_EN
  localparam int TO = 16;
`else
  localparam int TO = 65536;
`endif

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] dat;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] req_valid;
  logic [8*N-1:0] req_data;
  logic [N-1:0] req_lock;
  logic [N-1:0] req_ack;
  logic [7:0]   uart_data;
  logic         uart_ready;
  logic         uart_done;
  logic [1:0]   grant_id;
  logic         busy;
  logic         err;

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t exp_q [$];

  always #5 clk = ~clk;

  uart_tx_arbiter #(.N_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_lock(req_lock),
    .req_ack(req_ack), .uart_data(uart_data), .uart_ready(uart_ready), .uart_done(uart_done),
    .grant_id(grant_id), .busy(busy), .err(err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req_valid = '0; req_data = '0; req_lock = '0; uart_done = 1'b0;
    step(); step();
    rst = 1'b0;
  endtask

  // Waits (bounded) for uart_ready; an expired bound is reported as a failed comparison.
  task automatic wait_ready(input int budget, output int waited, output logic [7:0] d, output logic [1:0] g);
    waited = 0;
    while (uart_ready !== 1'b1 && waited < budget) begin
      step();
      waited++;
    end
    d = uart_data;
    g = grant_id;
    if (uart_ready !== 1'b1) begin
      n_cmp++; n_bad++;
      $display("FAIL wait_ready: uart_ready=%b after %0d cycles, required 1", uart_ready, waited);
    end
  endtask

  // Models the UART: n more SEND cycles, then a one-cycle done; returns in the GAP cycle.
  task automatic pulse_done(input int n);
    repeat (n) step();
    uart_done = 1'b1;
    step();
    uart_done = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (uart_ready !== 1'b0) begin n_bad++; $display("FAIL rst_ready: got %b required 0", uart_ready); end
    n_cmp++; if (uart_data !== 8'h00) begin n_bad++; $display("FAIL rst_data: got %h required 00", uart_data); end
    n_cmp++; if (req_ack !== 3'b000) begin n_bad++; $display("FAIL rst_ack: got %b required 000", req_ack); end
    n_cmp++; if (grant_id !== 2'd0) begin n_bad++; $display("FAIL rst_grant: got %0d required 0", grant_id); end
    n_cmp++; if (busy !== 1'b0 || err !== 1'b0) begin n_bad++; $display("FAIL rst_busy_err: got %b%b required 00", busy, err); end
  endtask

  task automatic test_single();
    exp_t e; logic [7:0] d0; int bad;
    do_reset();
    req_data = {8'h00, 8'h41, 8'h00}; req_valid = 3'b010;
    exp_q.push_back({2'd1, 8'h41});
    step();
    e = exp_q.pop_front();
    n_cmp++; if (uart_ready !== 1'b1) begin n_bad++; $display("FAIL single_latency: uart_ready=%b required 1", uart_ready); end
    n_cmp++; if (uart_data !== e.dat || grant_id !== e.id) begin
      n_bad++; $display("FAIL single_byte: data=%h id=%0d required data=%h id=%0d", uart_data, grant_id, e.dat, e.id); end
    d0 = uart_data; bad = 0;
    repeat (20) begin
      step();
      if (uart_ready !== 1'b1 || uart_data !== d0 || req_ack !== 3'b000) bad++;
    end
    n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL single_hold: %0d unstable SEND cycles, required 0", bad); end
    uart_done = 1'b1; step(); uart_done = 1'b0; req_valid = 3'b000;
    n_cmp++; if (req_ack !== 3'b010 || busy !== 1'b1 || err !== 1'b0) begin
      n_bad++; $display("FAIL single_ack: ack=%b busy=%b err=%b required 010 1 0", req_ack, busy, err); end
    step();
    n_cmp++; if (req_ack !== 3'b000 || busy !== 1'b0 || uart_ready !== 1'b0) begin
      n_bad++; $display("FAIL single_idle: ack=%b busy=%b ready=%b required 000 0 0", req_ack, busy, uart_ready); end
  endtask

  task automatic test_round_robin();
    exp_t e; int w; logic [7:0] d; logic [1:0] g; logic [2:0] ea;
    do_reset();
    req_data = {8'h12, 8'h11, 8'h10}; req_valid = 3'b111;
    exp_q.push_back({2'd0, 8'h10}); exp_q.push_back({2'd1, 8'h11});
    exp_q.push_back({2'd2, 8'h12}); exp_q.push_back({2'd0, 8'h10});
    for (int b = 0; b < 4; b++) begin
      wait_ready(8, w, d, g);
      e = exp_q.pop_front();
      n_cmp++; if (d !== e.dat || g !== e.id) begin
        n_bad++; $display("FAIL rr_byte%0d: data=%h id=%0d required data=%h id=%0d", b, d, g, e.dat, e.id); end
      if (b > 0) begin
        n_cmp++; if (w != 2) begin n_bad++; $display("FAIL rr_gap%0d: done-to-ready %0d cycles required 3", b, w + 1); end
      end
      pulse_done(4);
      ea = 3'b001 << e.id;
      n_cmp++; if (req_ack !== ea || err !== 1'b0) begin
        n_bad++; $display("FAIL rr_ack%0d: ack=%b err=%b required %b 0", b, req_ack, err, ea); end
    end
    req_valid = 3'b000;
    step(); step();
  endtask

  task automatic test_lock();
    exp_t e; int w; int bad; logic [7:0] d; logic [1:0] g;
    do_reset();
    req_data = {8'hC2, 8'h00, 8'hA0}; req_valid = 3'b101; req_lock = 3'b001;
    exp_q.push_back({2'd0, 8'hA0}); exp_q.push_back({2'd0, 8'hA1});
    exp_q.push_back({2'd0, 8'hA2}); exp_q.push_back({2'd2, 8'hC2});
    for (int b = 0; b < 4; b++) begin
      wait_ready(8, w, d, g);
      e = exp_q.pop_front();
      n_cmp++; if (d !== e.dat || g !== e.id) begin
        n_bad++; $display("FAIL lock_byte%0d: data=%h id=%0d required data=%h id=%0d", b, d, g, e.dat, e.id); end
      if (b == 2) req_lock = 3'b000;
      pulse_done(2);
      case (b)
        0: req_data[7:0] = 8'hA1;
        1: begin
          req_data[7:0] = 8'hA2; req_valid = 3'b100; bad = 0;
          repeat (4) begin
            step();
            if (uart_ready !== 1'b0 || busy !== 1'b0) bad++;
          end
          n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL lock_starve: %0d grants while locked owner idle, required 0", bad); end
          req_valid = 3'b101;
        end
        2: req_valid = 3'b100;
        default: req_valid = 3'b000;
      endcase
    end
    step(); step();
  endtask

  task automatic test_spurious_and_drop();
    exp_t e; int w; int bad; logic [7:0] d; logic [1:0] g;
    do_reset();
    uart_done = 1'b1; step(); uart_done = 1'b0;
    n_cmp++; if (req_ack !== 3'b000 || busy !== 1'b0 || uart_ready !== 1'b0) begin
      n_bad++; $display("FAIL spur_idle: ack=%b busy=%b ready=%b required 000 0 0", req_ack, busy, uart_ready); end
    req_data = {8'h00, 8'h00, 8'h55}; req_valid = 3'b001;
    exp_q.push_back({2'd0, 8'h55});
    wait_ready(8, w, d, g);
    e = exp_q.pop_front();
    n_cmp++; if (w != 1 || d !== e.dat || g !== e.id) begin
      n_bad++; $display("FAIL drop_grant: wait=%0d data=%h id=%0d required 1 %h %0d", w, d, g, e.dat, e.id); end
    req_valid = 3'b000; bad = 0;
    repeat (3) begin
      step();
      if (uart_ready !== 1'b1 || uart_data !== 8'h55) bad++;
    end
    n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL drop_hold: %0d cycles lost the byte, required 0", bad); end
    pulse_done(0);
    n_cmp++; if (req_ack !== 3'b001) begin n_bad++; $display("FAIL drop_ack: got %b required 001", req_ack); end
    uart_done = 1'b1; step(); uart_done = 1'b0;
    n_cmp++; if (req_ack !== 3'b000 || busy !== 1'b0 || uart_ready !== 1'b0) begin
      n_bad++; $display("FAIL spur_gap: ack=%b busy=%b ready=%b required 000 0 0", req_ack, busy, uart_ready); end
    step();
  endtask

  task automatic test_reset_mid_byte();
    exp_t e; int w; logic [7:0] d; logic [1:0] g;
    do_reset();
    req_data = {8'h33, 8'h00, 8'h77}; req_valid = 3'b001;
    exp_q.push_back({2'd0, 8'h77});
    wait_ready(8, w, d, g);
    e = exp_q.pop_front();
    n_cmp++; if (d !== e.dat || g !== e.id) begin
      n_bad++; $display("FAIL rmid_byte: data=%h id=%0d required %h %0d", d, g, e.dat, e.id); end
    step(); step(); step();
    rst = 1'b1; req_valid = 3'b000;
    step();
    n_cmp++; if (uart_ready !== 1'b0 || busy !== 1'b0 || req_ack !== 3'b000 || grant_id !== 2'd0) begin
      n_bad++; $display("FAIL rmid_state: ready=%b busy=%b ack=%b id=%0d required 0 0 000 0", uart_ready, busy, req_ack, grant_id); end
    rst = 1'b0; req_valid = 3'b100;
    exp_q.push_back({2'd2, 8'h33}); exp_q.push_back({2'd0, 8'hB0}); exp_q.push_back({2'd1, 8'hB1});
    for (int b = 0; b < 3; b++) begin
      wait_ready(8, w, d, g);
      e = exp_q.pop_front();
      n_cmp++; if (d !== e.dat || g !== e.id) begin
        n_bad++; $display("FAIL rmid_after%0d: data=%h id=%0d required %h %0d", b, d, g, e.dat, e.id); end
      pulse_done(2);
      if (b == 0) begin req_data = {8'h00, 8'hB1, 8'hB0}; req_valid = 3'b011; end
      else if (b == 1) req_valid = 3'b010;
      else req_valid = 3'b000;
    end
    step(); step();
  endtask

`ifdef UART_ARB_TIMEOUT_EN
  task automatic test_timeout();
    exp_t e; int w; int cnt; logic [7:0] d; logic [1:0] g;
    do_reset();
    req_data = {8'h00, 8'h22, 8'h21}; req_valid = 3'b011;
    exp_q.push_back({2'd0, 8'h21}); exp_q.push_back({2'd1, 8'h22});
    wait_ready(8, w, d, g);
    e = exp_q.pop_front();
    n_cmp++; if (d !== e.dat || g !== e.id) begin
      n_bad++; $display("FAIL to_byte: data=%h id=%0d required %h %0d", d, g, e.dat, e.id); end
    cnt = 0;
    while (uart_ready === 1'b1 && cnt < 40) begin step(); cnt++; end
    n_cmp++; if (cnt != 16) begin n_bad++; $display("FAIL to_len: %0d SEND cycles required 16", cnt); end
    n_cmp++; if (err !== 1'b1 || req_ack !== 3'b001) begin
      n_bad++; $display("FAIL to_abort: err=%b ack=%b required 1 001", err, req_ack); end
    wait_ready(8, w, d, g);
    e = exp_q.pop_front();
    n_cmp++; if (d !== e.dat || g !== e.id) begin
      n_bad++; $display("FAIL to_next: data=%h id=%0d required %h %0d", d, g, e.dat, e.id); end
    pulse_done(2);
    n_cmp++; if (err !== 1'b0 || req_ack !== 3'b010) begin
      n_bad++; $display("FAIL to_clean: err=%b ack=%b required 0 010", err, req_ack); end
    req_valid = 3'b000;
    step(); step();
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_lock();
    test_spurious_and_drop();
    test_reset_mid_byte();
`ifdef UART_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
